// File: rtl/riscv_csr_pkg.sv
// Shared machine-mode CSR definitions: addresses, cause codes and the trap sequencer state encoding.
package riscv_csr_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;
  localparam logic [11:0] MTVAL   = 12'h343;

  localparam logic [3:0] CAUSE_INSN_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSN    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT      = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M         = 4'd11;
  localparam logic [3:0] IRQ_M_SOFT            = 4'd3;
  localparam logic [3:0] IRQ_M_TIMER           = 4'd7;
  localparam logic [3:0] IRQ_M_EXT             = 4'd11;

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    W_TVAL,
    R_TVEC,
    R_EPC
  } trap_state_t;

endpackage

// File: rtl/trap_sequencer_if.sv
// Single read/write port into the machine-mode CSR file; read data is combinational.
interface trap_sequencer_if #(
  parameter int XLEN = 32
);
  logic [11:0]     csr_addr;
  logic            csr_w;
  logic [XLEN-1:0] csr_din;
  logic [XLEN-1:0] csr_dout;

  modport master (output csr_addr, output csr_w, output csr_din, input csr_dout);
  modport slave  (input csr_addr, input csr_w, input csr_din, output csr_dout);
endinterface

// File: rtl/trap_vector_calc.sv
// Trap target from mtvec. Build option TRAP_VECTORED_EN enables vectored interrupt targets.
module trap_vector_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic            intr,
  input  logic [3:0]      code,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] base;
  assign base = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  logic [XLEN-1:0] offset;
  assign offset = {{(XLEN-6){1'b0}}, code, 2'b00};
  // Modes 2 and 3 fall back to direct.
  assign target = (intr && mtvec[1:0] == 2'b01) ? base + offset : base;
`else
  logic unused_mode;
  assign unused_mode = ^{intr, code, mtvec[1:0]};
  assign target = base;
`endif

endmodule

// File: rtl/trap_sequencer.sv
// Owns the CSR file port: forwards execute accesses, or sequences trap entry / mret redirects.
// Target selection honours TRAP_VECTORED_EN through trap_vector_calc.
module trap_sequencer
  import riscv_csr_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      ex_csr_addr,
  input  logic             ex_csr_w,
  input  logic [XLEN-1:0]  ex_csr_din,
  output logic [XLEN-1:0]  ex_csr_dout,
  input  logic             exc_valid,
  input  logic [3:0]       exc_code,
  input  logic [XLEN-1:0]  exc_pc,
  input  logic [XLEN-1:0]  exc_tval,
  input  logic             irq_req,
  input  logic [3:0]       irq_code,
  input  logic [XLEN-1:0]  irq_pc,
  input  logic             mret_valid,
  output logic             trap_ack,
  output logic             busy,
  output logic             flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  trap_sequencer_if.master csr
);

  trap_state_t     state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] tval_q;
  logic [3:0]      code_q;
  logic            intr_q;
  logic            req_any;
  logic [XLEN-1:0] vec_target;

  assign req_any     = exc_valid | mret_valid | irq_req;
  assign busy        = (state != IDLE);
  assign trap_ack    = (state == IDLE) && req_any;
  assign ex_csr_dout = csr.csr_dout;

  trap_vector_calc #(.XLEN(XLEN)) u_vec (
    .mtvec  (csr.csr_dout),
    .intr   (intr_q),
    .code   (code_q),
    .target (vec_target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pc_q           <= '0;
      tval_q         <= '0;
      code_q         <= '0;
      intr_q         <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      case (state)
        IDLE: begin
          // Priority exc > mret > irq; losers are dropped, a level irq returns later.
          if (exc_valid) begin
            state  <= W_EPC;
            pc_q   <= exc_pc;
            code_q <= exc_code;
            tval_q <= exc_tval;
            intr_q <= 1'b0;
            flush  <= 1'b1;
          end else if (mret_valid) begin
            state <= R_EPC;
            flush <= 1'b1;
          end else if (irq_req) begin
            state  <= W_EPC;
            pc_q   <= irq_pc;
            code_q <= irq_code;
            tval_q <= '0;
            intr_q <= 1'b1;
            flush  <= 1'b1;
          end
        end
        W_EPC:   state <= W_CAUSE;
        W_CAUSE: state <= W_TVAL;
        W_TVAL:  state <= R_TVEC;
        R_TVEC: begin
          state          <= IDLE;
          redirect_valid <= 1'b1;
          redirect_pc    <= vec_target;
        end
        R_EPC: begin
          state          <= IDLE;
          redirect_valid <= 1'b1;
          redirect_pc    <= csr.csr_dout;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    csr.csr_addr = ex_csr_addr;
    csr.csr_w    = 1'b0;
    csr.csr_din  = '0;
    case (state)
      IDLE: begin
        csr.csr_addr = ex_csr_addr;
        csr.csr_w    = ex_csr_w & ~req_any;
        csr.csr_din  = ex_csr_din;
      end
      W_EPC: begin
        csr.csr_addr = MEPC;
        csr.csr_w    = 1'b1;
        csr.csr_din  = {pc_q[XLEN-1:1], 1'b0};
      end
      W_CAUSE: begin
        csr.csr_addr = MCAUSE;
        csr.csr_w    = 1'b1;
        csr.csr_din  = {intr_q, {(XLEN-5){1'b0}}, code_q};
      end
      W_TVAL: begin
        csr.csr_addr = MTVAL;
        csr.csr_w    = 1'b1;
        csr.csr_din  = tval_q;
      end
      R_TVEC:  csr.csr_addr = MTVEC;
      R_EPC:   csr.csr_addr = MEPC;
      default: csr.csr_addr = ex_csr_addr;
    endcase
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Sits directly upstream of the machine-mode CSR file and owns its single read/write port.
- In normal operation, forwards CSR-instruction accesses from execute unchanged.
- On an exception or interrupt, takes the port and writes mepc, mcause and mtval in sequence, reads mtvec, then issues a one-cycle PC redirect.
- On mret, reads mepc and redirects to it.

Parameters:
- XLEN, 32, data/address width; matches the CSR file.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_csr_addr  in  12  CSR address from execute.
- ex_csr_w  in  1  CSR write strobe from execute.
- ex_csr_din  in  XLEN  CSR write data from execute.
- ex_csr_dout  out  XLEN  read data returned to execute; equals csr_dout.
- exc_valid  in  1  synchronous exception request.
- exc_code  in  4  exception cause code.
- exc_pc  in  XLEN  PC of the faulting instruction.
- exc_tval  in  XLEN  trap value.
- irq_req  in  1  interrupt request; level, already masked and prioritised upstream.
- irq_code  in  4  interrupt cause code (3, 7 or 11).
- irq_pc  in  XLEN  PC of the next instruction to execute.
- mret_valid  in  1  mret retiring.
- trap_ack  out  1  request accepted this cycle.
- busy  out  1  sequencer owns the CSR port.
- flush  out  1  kill younger pipeline instructions.
- redirect_valid  out  1  one-cycle redirect pulse.
- redirect_pc  out  XLEN  redirect target.
- csr_addr  out  12  to CSR file.
- csr_w  out  1  to CSR file.
- csr_din  out  XLEN  to CSR file.
- csr_dout  in  XLEN  from CSR file; combinational read.

Behaviour:
- Reset and clock: one clock, clk. rst is synchronous and active-high.
  - On rst, from any state: state=IDLE, all latched fields cleared, redirect_valid=0, redirect_pc=0, flush=0.
  - A trap in progress is abandoned; no further CSR writes are issued after the reset edge.
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, R_TVEC, R_EPC.
- IDLE, no request: csr_addr/csr_w/csr_din = ex_* passthrough. busy=0.
- IDLE, request present: priority is exc_valid > mret_valid > irq_req.
  - trap_ack=1 (combinational) in the acceptance cycle N.
  - ex_csr_w is suppressed in cycle N; the trapping instruction does not commit.
  - Lower-priority requests are dropped. irq_req, being level, is retaken later if still high.
  - Latched on accept: pc, code, tval (0 for interrupts), interrupt flag.
- Trap path, with request accepted in cycle N:
  - N+1 W_EPC: addr 0x341, w=1, din=pc with bit0 cleared. flush=1 (this cycle only).
  - N+2 W_CAUSE: addr 0x342, w=1, din={intr, zero-extended code}.
  - N+3 W_TVAL: addr 0x343, w=1, din=tval.
  - N+4 R_TVEC: addr 0x305, w=0; the target is computed from csr_dout.
  - N+5: back in IDLE; redirect_valid=1 and redirect_pc registered. Both are held for one cycle only.
- mret path, with mret accepted in cycle N:
  - N+1 R_EPC: addr 0x341, w=0. flush=1.
  - N+2: IDLE; redirect_valid=1, redirect_pc=csr_dout registered.
- Target computation: direct mode, target = {mtvec[XLEN-1:2], 2'b00}.
- busy = (state != IDLE). While busy=1:
  - ex_csr_w is ignored.
  - ex_csr_dout still mirrors csr_dout.
  - New requests are ignored; no trap_ack.
- A new request may be accepted in the same cycle redirect_valid is high.
- The sequencer performs no cause filtering. The CSR file silently drops illegal mcause codes (e.g. interrupt code 2).
- Arithmetic is XLEN-wide; overflow wraps modulo 2^XLEN.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: if mtvec[1:0]==1 and the trap is an interrupt, target = base + 4*code. Otherwise the target is base.
- Undefined: mtvec[1:0] is ignored and the target is always base.
- Modes 2 and 3 are treated as direct in both builds.

Decomposition:
- Shared package riscv_csr_pkg holds:
  - CSR address constants: MSTATUS, MTVEC, MEPC, MCAUSE, MTVAL.
  - Cause-code constants.
  - The state enum.
  - XLEN default.
- One sub-module, trap_vector_calc: combinational target computation from mtvec, intr and code. It contains the TRAP_VECTORED_EN logic.

Test Plan:
- Exception: exc_valid=1, exc_code=2, exc_pc=0x1003, exc_tval=0xDEAD, mtvec=0x8000_0100.
  -> writes in order: mepc=0x1002, mcause=0x0000_0002, mtval=0xDEAD.
  -> redirect_valid=1 with redirect_pc=0x8000_0100 exactly 5 cycles after trap_ack; flush for one cycle.
- Vectored interrupt (TRAP_VECTORED_EN defined): irq_req=1, irq_code=7, irq_pc=0x2000, mtvec=0x8000_0101.
  -> mcause=0x8000_0007, mtval=0, redirect_pc=0x8000_011C.
  -> With the macro undefined -> redirect_pc=0x8000_0100.
- Simultaneous exc_valid, mret_valid and irq_req in IDLE.
  -> exception taken; mret is dropped.
  -> The held irq is accepted in the cycle redirect_valid is high.
- mret with mepc=0x4000 -> R_EPC read of 0x341; redirect_pc=0x4000 two cycles after trap_ack.
- ex_csr_w=1 to mscratch while busy, and in the acceptance cycle -> mscratch unchanged. The same write in IDLE with no request -> committed.
- rst asserted during W_CAUSE.
  -> next cycle: IDLE, csr_w=0, no mtval write, no redirect_valid.
  -> mepc keeps the value already written.
